serial_rho_stream: RTL and testbench

Column-serial, parametrised implementation of the SWAN rho linear layer. It accepts one half-state column per cycle and buffers all columns while accumulating their XOR. It then emits each output column as that XOR combined with the buffered input column, which equals the XOR of all other input columns. The block sits between the serial round datapath and the serial key-mixing stage, and is used where a full-width combinational rho is too costly in area; valid/ready handshakes on both sides give it backpressure support.

---
 rtl/serial_rho_stream_if.sv | 24 ++
 rtl/serial_rho_stream.sv | 101 ++++++++++
 tb/tb_serial_rho_stream.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rho_stream_if.sv
// Column stream bundle for serial_rho_stream: input/output valid-ready pairs plus status.
// The slave modport is the rho block; the master modport is its surrounding datapath.
interface serial_rho_stream_if #(
    parameter int unsigned COLUMN_SIZE = 32
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [COLUMN_SIZE-1:0] in_col;
    logic                   out_valid;
    logic                   out_ready;
    logic [COLUMN_SIZE-1:0] out_col;
    logic                   out_last;
    logic                   busy;

    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_col, out_last, busy
    );

    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_col, out_last, busy
    );
endinterface

// File: rtl/serial_rho_stream.sv
// Column-serial SWAN rho layer: buffers one half-state while XOR-accumulating it, then emits
// each column as the total XOR with that column's own contribution cancelled out.
module serial_rho_stream #(
    parameter int unsigned COLUMN_SIZE = 32,
    parameter int unsigned COLUMNS     = 4,
    parameter int unsigned IDX_W       = $clog2(COLUMNS)
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_rho_stream_if.slave  io_rho
);

    if ((COLUMNS < 2) || ((COLUMNS % 2) != 0)) begin : g_bad_columns
        $error("serial_rho_stream: COLUMNS must be even and at least 2");
    end

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(COLUMNS - 1);

    typedef enum logic {StLoad, StEmit} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic [COLUMN_SIZE-1:0] r_acc;
    logic [COLUMN_SIZE-1:0] w_acc_nxt;
    logic [COLUMN_SIZE-1:0] r_col_buf [COLUMNS];
    logic                   r_in_ready;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_last;

    assign w_last     = (r_idx == LastIdx);
    assign w_in_xfer  = io_rho.in_valid & r_in_ready;
    assign w_out_xfer = (r_state == StEmit) & io_rho.out_ready;

    // in_ready is registered from the next state so it stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StLoad;
            r_idx      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_in_ready <= (w_state_nxt == StLoad);
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_xfer) begin
            r_col_buf[r_idx] <= io_rho.in_col;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;
        unique case (r_state)
            StLoad: begin
                if (w_in_xfer) begin
                    w_acc_nxt = r_acc ^ io_rho.in_col;
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = StEmit;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            StEmit: begin
                if (w_out_xfer) begin
                    if (w_last) begin
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                        w_state_nxt = StLoad;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    always_comb begin
        io_rho.in_ready  = r_in_ready;
        io_rho.out_valid = (r_state == StEmit);
        io_rho.out_last  = (r_state == StEmit) & w_last;
        io_rho.busy      = (r_state == StEmit) | (r_idx != '0);
        io_rho.out_col   = '0;
        if (r_state == StEmit) begin
            // acc holds every column, so XOR with buf[idx] removes column idx
            io_rho.out_col = r_acc ^ r_col_buf[r_idx];
        end
    end

endmodule

// File: tb/tb_serial_rho_stream.sv
// Self-checking bench for serial_rho_stream: directed table, reset/abort sequences,
// a COLUMNS=2 instance and a throttled random regression against an XOR reference model.
module tb_serial_rho_stream;

    typedef struct packed {
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0]       gap;
        logic [3:0]       stall;
    } vec_t;

    localparam int NBlk = 1000;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    vec_t tbl [6];
    logic [31:0] stim [NBlk*4];

    serial_rho_stream_if #(.COLUMN_SIZE(32)) ifc ();
    serial_rho_stream_if #(.COLUMN_SIZE(8))  ifc2 ();

    serial_rho_stream #(.COLUMN_SIZE(32), .COLUMNS(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_rho (ifc)
    );

    serial_rho_stream #(.COLUMN_SIZE(8), .COLUMNS(2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_rho (ifc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3,
                                input int gap, input int stall);
        vec_t v;
        v.a = {a3, a2, a1, a0};
        v.b = {b3, b2, b1, b0};
        v.gap = 4'(gap);
        v.stall = 4'(stall);
        return v;
    endfunction

    // Present one column and hold it until the block takes it.
    task automatic send_col(input logic [31:0] d, output int c);
        int t = 0;
        ifc.in_valid = 1'b1;
        ifc.in_col   = d;
        @(negedge clk);
        while (!ifc.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.in_ready) check("send_timeout", 32'(ifc.in_ready), 32'd1);
        c = cyc;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic idle_in(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Accept one output column, first stalling it for 'stall' cycles.
    task automatic recv_col(input int stall, output logic [31:0] d, output logic l,
                            output int c);
        int t = 0;
        ifc.out_ready = (stall == 0);
        @(negedge clk);
        while (!ifc.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ifc.out_valid) check("recv_timeout", 32'(ifc.out_valid), 32'd1);
        d = ifc.out_col;
        l = ifc.out_last;
        check("emit_in_ready", 32'(ifc.in_ready), 32'd0);
        check("emit_busy", 32'(ifc.busy), 32'd1);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_col", ifc.out_col, d);
            check("stall_last", 32'(ifc.out_last), 32'(l));
            check("stall_valid", 32'(ifc.out_valid), 32'd1);
            check("stall_in_ready", 32'(ifc.in_ready), 32'd0);
        end
        ifc.out_ready = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] got [4];
        logic        lst [4];
        int          c_in [4];
        int          c_out [4];
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    if (i == 2) idle_in(int'(v.gap));
                    send_col(v.a[i], c_in[i]);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    recv_col((j == 1) ? int'(v.stall) : 0, got[j], lst[j], c_out[j]);
                end
            end
        join
        for (int j = 0; j < 4; j++) begin
            check($sformatf("vec_col%0d", j), got[j], v.b[j]);
            check($sformatf("vec_last%0d", j), 32'(lst[j]), (j == 3) ? 32'd1 : 32'd0);
        end
        if (v.stall == 0) begin
            check("latency_first", 32'(c_out[0]), 32'(c_in[3] + 1));
            check("latency_burst", 32'(c_out[3]), 32'(c_in[3] + 4));
        end
        check("done_busy", 32'(ifc.busy), 32'd0);
        check("done_in_ready", 32'(ifc.in_ready), 32'd1);
    endtask

    initial begin
        int          c;
        logic [31:0] d;
        logic        l;
        logic [1:0][7:0] t2a [2];
        logic [1:0][7:0] t2b [2];

        n_cmp  = 0;
        n_fail = 0;
        tbl[0] = mk(32'h1, 32'h2, 32'h4, 32'h8, 32'hE, 32'hD, 32'hB, 32'h7, 0, 0);
        tbl[1] = mk(32'hE, 32'hD, 32'hB, 32'h7, 32'h1, 32'h2, 32'h4, 32'h8, 0, 0);
        tbl[2] = mk(32'h1, 32'h2, 32'h4, 32'h8, 32'hE, 32'hD, 32'hB, 32'h7, 2, 3);
        tbl[3] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
        tbl[4] = mk(32'h12345678, 32'h0, 32'h0, 32'h0,
                    32'h0, 32'h12345678, 32'h12345678, 32'h12345678, 0, 1);
        tbl[5] = mk(32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0,
                    32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 1, 0);
        for (int k = 0; k < NBlk * 4; k++) stim[k] = $urandom;

        rst_n = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_col = '0;
        ifc.out_ready = 1'b0;
        ifc2.in_valid = 1'b0;
        ifc2.in_col = '0;
        ifc2.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_last", 32'(ifc.out_last), 32'd0);
        check("rst_busy", 32'(ifc.busy), 32'd0);
        check("rst_out_col", ifc.out_col, 32'd0);
        check("rst2_in_ready", 32'(ifc2.in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready_low", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", 32'(ifc.in_ready), 32'd1);

        for (int v = 0; v < 6; v++) run_vec(tbl[v]);

        // Abort during LOAD after two columns.
        send_col(32'hAAAAAAAA, c);
        send_col(32'h55555555, c);
        check("load_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_load_busy", 32'(ifc.busy), 32'd0);
        check("abort_load_in_ready", 32'(ifc.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[3]);

        // Abort during EMIT after one output column.
        for (int i = 0; i < 4; i++) send_col(tbl[0].a[i], c);
        recv_col(0, d, l, c);
        check("abort_emit_pre_col", d, 32'hE);
        rst_n = 1'b0;
        #1;
        check("abort_emit_valid", 32'(ifc.out_valid), 32'd0);
        check("abort_emit_col", ifc.out_col, 32'd0);
        check("abort_emit_busy", 32'(ifc.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(tbl[1]);

        // COLUMNS=2 instance: a swap, and its own inverse.
        t2a[0] = {8'hA5, 8'h3C};
        t2b[0] = {8'h3C, 8'hA5};
        t2a[1] = {8'h3C, 8'hA5};
        t2b[1] = {8'hA5, 8'h3C};
        for (int v = 0; v < 2; v++) begin
            @(posedge clk);
            #1;
            ifc2.in_valid = 1'b1;
            ifc2.in_col = t2a[v][0];
            @(negedge clk);
            check("c2_in_ready0", 32'(ifc2.in_ready), 32'd1);
            @(posedge clk);
            #1;
            ifc2.in_col = t2a[v][1];
            @(negedge clk);
            check("c2_in_ready1", 32'(ifc2.in_ready), 32'd1);
            @(posedge clk);
            #1;
            ifc2.in_valid = 1'b0;
            @(negedge clk);
            check("c2_valid0", 32'(ifc2.out_valid), 32'd1);
            check("c2_col0", 32'(ifc2.out_col), 32'(t2b[v][0]));
            check("c2_last0", 32'(ifc2.out_last), 32'd0);
            @(negedge clk);
            check("c2_col1", 32'(ifc2.out_col), 32'(t2b[v][1]));
            check("c2_last1", 32'(ifc2.out_last), 32'd1);
            @(posedge clk);
            #1;
            check("c2_done_busy", 32'(ifc2.busy), 32'd0);
        end

        // Random regression: producer runs ahead, so in_valid is often held across EMIT.
        fork
            begin
                int ci;
                for (int k = 0; k < NBlk * 4; k++) begin
                    if ($urandom_range(0, 3) == 0) idle_in(int'($urandom_range(1, 2)));
                    send_col(stim[k], ci);
                end
            end
            begin
                logic [31:0] got;
                logic [31:0] exp;
                logic        lst;
                int          co;
                int          st;
                for (int k = 0; k < NBlk * 4; k++) begin
                    st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                    recv_col(st, got, lst, co);
                    exp = '0;
                    for (int i = 0; i < 4; i++) begin
                        if (i != k % 4) exp = exp ^ stim[(k / 4) * 4 + i];
                    end
                    check("rand_col", got, exp);
                    check("rand_last", 32'(lst), (k % 4 == 3) ? 32'd1 : 32'd0);
                end
            end
        join
        check("rand_done_busy", 32'(ifc.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
